// File: rtl/front_panel_sync_pkg.sv
// Shared constants for the front panel synchronizer:
// debounce lengths, FSM encoding and key priority indices.
package front_panel_sync_pkg;

  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int DEBOUNCE_CYCLES_HW  = 100000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Lower index wins when several keys are pressed.
  localparam int K_CLEAR     = 0;
  localparam int K_ADDR_LOAD = 1;
  localparam int K_EXTD_ADDR = 2;
  localparam int K_DEP       = 3;
  localparam int K_EXAM      = 4;
  localparam int K_CONT      = 5;
  localparam int NKEYS       = 6;

  function automatic logic [NKEYS-1:0] prio_sel(
    input logic [NKEYS-1:0] p
  );
    return p & (~p + NKEYS'(1));
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a saturating
// stable-sample debouncer for one front panel input.
module sw_debounce #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic INIT            = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [1:0]    vld;
  logic [CW-1:0] cnt;

  // Reset-preloaded sync flops are not real samples; vld
  // holds off counting until the pipeline has refilled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync  <= 2'b11;
      vld   <= 2'b00;
      cnt   <= '0;
      level <= INIT;
    end else begin
      sync <= {sync[0], raw};
      vld  <= {vld[0], 1'b1};
      if (!vld[1] || sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/front_panel_sync.sv
// Front panel key/switch conditioning: debounce all inputs
// and turn momentary key presses into one-clk commands.
module front_panel_sync
  import front_panel_sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic contn,
  input  logic examn,
  input  logic depn,
  input  logic addr_loadn,
  input  logic extd_addrn,
  input  logic clearn,
  input  logic haltn,
  input  logic single_stepn,
  output logic cont_p,
  output logic exam_p,
  output logic dep_p,
  output logic addr_load_p,
  output logic extd_addr_p,
  output logic clear_p,
  output logic halt,
  output logic single_step,
  output logic reject_p
);

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_lvl;
  logic [NKEYS-1:0] pressed;
  logic [NKEYS-1:0] cmd;
  logic             halt_lvl;
  logic             step_lvl;
  logic [0:0]       state;
  logic             reject;

  assign key_raw = {contn, examn, depn,
                    extd_addrn, addr_loadn, clearn};

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (1'b1)
    ) u_key (
      .clk   (clk),
      .resetn(resetn),
      .raw   (key_raw[i]),
      .level (key_lvl[i])
    );
  end

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INIT           (1'b0)
  ) u_halt (
    .clk   (clk),
    .resetn(resetn),
    .raw   (haltn),
    .level (halt_lvl)
  );

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INIT           (1'b1)
  ) u_step (
    .clk   (clk),
    .resetn(resetn),
    .raw   (single_stepn),
    .level (step_lvl)
  );

  assign pressed = ~key_lvl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cmd    <= '0;
      reject <= 1'b0;
    end else begin
      cmd    <= '0;
      reject <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|pressed) begin
            state <= ST_HELD;
            if (run) reject <= 1'b1;
            else     cmd    <= prio_sel(pressed);
          end
        end
        ST_HELD: begin
          if (!(|pressed)) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign clear_p     = cmd[K_CLEAR];
  assign addr_load_p = cmd[K_ADDR_LOAD];
  assign extd_addr_p = cmd[K_EXTD_ADDR];
  assign dep_p       = cmd[K_DEP];
  assign exam_p      = cmd[K_EXAM];
  assign cont_p      = cmd[K_CONT];
  assign reject_p    = reject;
  assign halt        = ~halt_lvl;
  assign single_step = ~step_lvl;

endmodule

// File: tb/tb_front_panel_sync.sv
// Directed bench for front_panel_sync with a cycle-level
// reference model built from the debounce/command rules.
module tb_front_panel_sync;
  import front_panel_sync_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic run = 1'b0;
  logic contn = 1'b1, examn = 1'b1, depn = 1'b1;
  logic addr_loadn = 1'b1, extd_addrn = 1'b1;
  logic clearn = 1'b1, haltn = 1'b1, single_stepn = 1'b1;
  logic cont_p, exam_p, dep_p, addr_load_p;
  logic extd_addr_p, clear_p, halt, single_step, reject_p;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int pc[7];
  int fe[7];

  front_panel_sync #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .resetn(resetn), .run(run),
    .contn(contn), .examn(examn), .depn(depn),
    .addr_loadn(addr_loadn), .extd_addrn(extd_addrn),
    .clearn(clearn), .haltn(haltn),
    .single_stepn(single_stepn),
    .cont_p(cont_p), .exam_p(exam_p), .dep_p(dep_p),
    .addr_load_p(addr_load_p), .extd_addr_p(extd_addr_p),
    .clear_p(clear_p), .halt(halt),
    .single_step(single_step), .reject_p(reject_p)
  );

  always #42 clk = ~clk;

  always @(posedge clk) edge_n++;

  // Reference model: a raw level is seen by the debouncer two
  // samples late, and flips it after N+1 differing samples.
  logic [7:0] rawq[$];
  logic [7:0] m_lvl;
  int         m_run[8];
  bit         m_held;
  logic [5:0] m_cmd;
  logic       m_rej;
  logic [7:0] rawv;
  assign rawv = {single_stepn, haltn, contn, examn, depn,
                 extd_addrn, addr_loadn, clearn};

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rawq.delete();
      m_lvl  = 8'b1011_1111;
      m_held = 1'b0;
      m_cmd  = '0;
      m_rej  = 1'b0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      logic [5:0] pr;
      pr    = ~m_lvl[5:0];
      m_cmd = '0;
      m_rej = 1'b0;
      if (!m_held && pr != 0) begin
        m_held = 1'b1;
        if (run) m_rej = 1'b1;
        else begin
          for (int i = 5; i >= 0; i--)
            if (pr[i]) m_cmd = 6'(1 << i);
        end
      end else if (m_held && pr == 0) begin
        m_held = 1'b0;
      end
      rawq.push_back(rawv);
      if (rawq.size() > 3) void'(rawq.pop_front());
      for (int i = 0; i < 8; i++) begin
        if (rawq.size() == 3 && rawq[0][i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == N + 1) begin
            m_lvl[i] = rawq[0][i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] act, exp;
    act = {cont_p, exam_p, dep_p, extd_addr_p, addr_load_p,
           clear_p, reject_p, halt, single_step};
    exp = {m_cmd, m_rej, ~m_lvl[6], ~m_lvl[7]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model_cmp edge %0d: got %b want %b",
               edge_n, act, exp);
    end
    for (int i = 0; i < 6; i++)
      if (act[3 + i] === 1'b1) begin
        pc[i]++;
        if (fe[i] < 0) fe[i] = edge_n;
      end
    if (reject_p === 1'b1) begin
      pc[6]++;
      if (fe[6] < 0) fe[6] = edge_n;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 7; i++) begin
      pc[i] = 0;
      fe[i] = -1;
    end
  endtask

  task automatic check(input string name, input int act,
                       input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  int e0;
  int cmd_sum;

  initial begin
    clr();
    tick(3);
    check("reset_halt", int'(halt), 1);
    check("reset_step", int'(single_step), 0);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("halt_after_edge%0d", i),
            int'(halt), (i < 6) ? 1 : 0);
    end
    tick(1000);
    cmd_sum = 0;
    for (int i = 0; i < 7; i++) cmd_sum += pc[i];
    check("idle_no_pulses", cmd_sum, 0);

    clr();
    contn = 1'b0;
    e0 = edge_n + 1;
    tick(20);
    contn = 1'b1;
    tick(20);
    check("cont_count", pc[K_CONT], 1);
    check("cont_latency", fe[K_CONT] - e0, 7);

    clr();
    clearn = 1'b0;
    depn   = 1'b0;
    tick(20);
    check("clear_count", pc[K_CLEAR], 1);
    check("dep_masked", pc[K_DEP], 0);
    clearn = 1'b1;
    depn   = 1'b1;
    tick(20);
    depn = 1'b0;
    tick(20);
    depn = 1'b1;
    tick(20);
    check("dep_count", pc[K_DEP], 1);
    check("clear_once", pc[K_CLEAR], 1);

    clr();
    run = 1'b1;
    addr_loadn = 1'b0;
    tick(10);
    check("reject_count", pc[6], 1);
    run = 1'b0;
    tick(10);
    check("addr_held_none", pc[K_ADDR_LOAD], 0);
    addr_loadn = 1'b1;
    tick(20);
    check("addr_rel_none", pc[K_ADDR_LOAD], 0);
    addr_loadn = 1'b0;
    tick(20);
    addr_loadn = 1'b1;
    tick(20);
    check("addr_repress", pc[K_ADDR_LOAD], 1);
    check("reject_once", pc[6], 1);

    clr();
    repeat (10) begin
      examn = 1'b0;
      tick(3);
      examn = 1'b1;
      tick(3);
    end
    tick(20);
    check("exam_glitch", pc[K_EXAM], 0);

    clr();
    haltn = 1'b0;
    single_stepn = 1'b0;
    tick(6);
    check("halt_pre", int'(halt), 0);
    tick();
    check("halt_set", int'(halt), 1);
    check("step_set", int'(single_step), 1);
    haltn = 1'b1;
    single_stepn = 1'b1;
    tick(10);
    check("halt_clr", int'(halt), 0);
    check("step_clr", int'(single_step), 0);

    clr();
    contn = 1'b0;
    tick(6);
    resetn = 1'b0;
    tick(3);
    check("cont_aborted", pc[K_CONT], 0);
    resetn = 1'b1;
    e0 = edge_n + 1;
    tick(15);
    check("cont_after_rst", pc[K_CONT], 1);
    check("cont_rst_latency", fe[K_CONT] - e0, 7);
    contn = 1'b1;
    tick(20);
    check("cont_final", pc[K_CONT], 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/front_panel_sync.md
FRONT_PANEL_SYNC -- requirements
Module: front_panel_sync

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized samples needed to accept a switch change (range 1..2^20).
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock, the only clock.
- resetn  input  1  asynchronous, active-low reset.
- run  input  1  CPU running flag (1 = running).
- contn, examn, depn, addr_loadn, extd_addrn, clearn  input  1 each  raw momentary keys, active-low.
- haltn, single_stepn  input  1 each  raw toggle switches, active-low.
- cont_p, exam_p, dep_p, addr_load_p, extd_addr_p, clear_p  output  1 each  one-clk command pulses.
- halt, single_step  output  1 each  debounced levels, active-high.
- reject_p  output  1  one-clk pulse: key press refused.

Function
REQ-003 Each of the 8 raw inputs SHALL pass through a two-flop synchronizer before any other use.
REQ-004 Each synchronized input SHALL drive its own debouncer:
- It keeps a debounced state and a stable counter.
- The debounced state changes only after DEBOUNCE_CYCLES consecutive cycles in which the synchronized value differs from it.
- Any sample equal to the debounced state SHALL clear the counter.
REQ-005 The debounced state SHALL change exactly 2+DEBOUNCE_CYCLES clk edges after the first edge that samples a steady new raw level.
REQ-006 halt and single_step SHALL equal the inverted debounced haltn and single_stepn states.
REQ-007 The momentary keys SHALL be handled by a two-state FSM, IDLE and HELD.
REQ-008 In IDLE, when at least one debounced momentary key is pressed, the FSM SHALL go to HELD on the next edge. In the same cycle as that transition:
- If run=0, it SHALL assert exactly one command pulse, for the highest-priority pressed key. Priority order: clear, addr_load, extd_addr, dep, exam, cont.
- If run=1, it SHALL assert reject_p and no command pulse.
REQ-009 Command pulses and reject_p SHALL be registered and last exactly one clk.
REQ-010 The first pulse SHALL appear 3+DEBOUNCE_CYCLES edges after the first edge sampling the key low.
REQ-011 In HELD, no pulse SHALL be produced. The FSM SHALL return to IDLE when all six debounced keys are released.
REQ-012 Keys pressed or released while in HELD SHALL never generate pulses; every new command requires all keys released first.
REQ-013 If two keys become debounced-pressed in the same cycle, only the higher-priority key SHALL pulse.
REQ-014 A change in run during HELD SHALL have no effect. run SHALL be sampled only in the IDLE-to-HELD cycle.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-016 The stable counters SHALL saturate and never wrap.

Reset
REQ-017 While resetn=0, all command pulses and reject_p SHALL be 0 and the FSM SHALL be IDLE.
REQ-018 During reset, all momentary debounced states SHALL be released, halt SHALL be 1, single_step SHALL be 0, all counters SHALL be 0, and all synchronizer flops SHALL be 1 (inactive).
REQ-019 If a key is held low through reset deassertion, it SHALL be debounced as a new press and produce one pulse, subject to run.
REQ-020 Reset asserted mid-debounce or in HELD SHALL abort immediately, with no pulse.

Structure
REQ-021 The shared parameters file SHALL hold:
- DEBOUNCE_CYCLES default values for simulation and hardware.
- The FSM state encoding (IDLE=0, HELD=1).
- The key priority index constants.
REQ-022 Synchronizer plus debouncer SHALL be one sub-module, sw_debounce, instantiated 8 times, with parameter DEBOUNCE_CYCLES and reset polarity parameter INIT.
REQ-023 The priority select and FSM SHALL reside in front_panel_sync. Implementation SHALL be 120-400 lines.

Verification (DEBOUNCE_CYCLES=4, clk period 84 ns)
REQ-024 Reset release with all inputs high SHALL give:
- halt=1 for 6 edges, then halt=0.
- No pulses for 1000 cycles.
REQ-025 With run=0, contn low for 20 cycles then high SHALL give:
- cont_p high exactly once, 7 edges after the first edge sampling contn low.
- No further pulse after release.
REQ-026 With run=0, clearn and depn dropped on the same edge and held SHALL give:
- One clear_p.
- dep_p never asserted.
- After both are released, a depn-only press SHALL give one dep_p.
REQ-027 With run=1, addr_loadn held low for 10 cycles SHALL give:
- One reject_p.
- No command pulses.
- Dropping run to 0 while the key is still held SHALL produce nothing until release and re-press.
REQ-028 examn pulsed low for 3 cycles, repeated with 3-cycle gaps 10 times, SHALL produce no exam_p.
REQ-029 resetn asserted 2 cycles before an expected cont_p SHALL suppress cont_p. With contn still low after reset release, exactly one cont_p SHALL occur 7 edges after release.
